// File: rtl/svr_read_sched.sv
// Read scheduler for the SVR single 128-bit read port.
// Two requesters are arbitrated round-robin. A granted request is sequenced
// as 1 or 4 four-word beats, assembled into a 512-bit operand, and held
// until the requester accepts it.
module svr_read_sched #(
    parameter int NREQ = 2,
    parameter int AW   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    input  logic [NREQ-1:0][1:0]     req_vl,
    output logic [AW-1:0]            svr_ra,
    input  logic [127:0]             svr_rd,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [511:0]             rsp_data,
    output logic                     rsp_err
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t           state_q, state_d;
    logic             prio_q;      // requester that wins a tie
    logic [AW-1:0]    addr_q;
    logic [1:0]       vl_q;
    logic             id_q;
    logic [1:0]       beat_q;
    logic [3:0][127:0] data_q;
    logic             err_q;

    logic             gnt_any;
    logic             gnt_id;
    logic             hs;
    logic             last_beat;

    // Winner: the preferred requester if it is valid, otherwise the other one.
    assign gnt_any   = |req_valid;
    assign gnt_id    = req_valid[prio_q] ? prio_q : ~prio_q;
    assign hs        = (state_q == IDLE) && gnt_any;
    // Only VL=10 spans four beats; every other length finishes in one.
    assign last_beat = (vl_q == 2'b10) ? (beat_q == 2'd3) : 1'b1;

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

    // Grant decode and read address; address wraps naturally in AW bits.
    always_comb begin
        req_ready = '0;
        svr_ra    = '0;
        if (hs)
            req_ready[gnt_id] = 1'b1;
        if (state_q == READ)
            svr_ra = addr_q + AW'({beat_q, 2'b00});
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hs) state_d = (req_vl[gnt_id] == 2'b11) ? RESP : READ;
            READ: if (last_beat) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request capture, beat assembly and arbiter pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
            addr_q <= '0;
            vl_q   <= '0;
            id_q   <= 1'b0;
            beat_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (hs) begin
            prio_q <= ~gnt_id;
            addr_q <= req_addr[gnt_id];
            vl_q   <= req_vl[gnt_id];
            id_q   <= gnt_id;
            beat_q <= '0;
            data_q <= '0;
            err_q  <= (req_vl[gnt_id] == 2'b11);
        end else if (state_q == READ) begin
            // Single-word reads still fetch four words; keep only word 0.
            data_q[beat_q] <= (vl_q == 2'b00) ? {96'b0, svr_rd[31:0]} : svr_rd;
            if (!last_beat)
                beat_q <= beat_q + 2'd1;
        end
    end

endmodule

// File: tb/tb_svr_read_sched.sv
// Bench for svr_read_sched: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_svr_read_sched;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][4:0]  req_addr = '0;
    logic [1:0][1:0]  req_vl = '0;
    logic [4:0]       svr_ra;
    logic [127:0]     svr_rd;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic             rsp_id;
    logic [511:0]     rsp_data;
    logic             rsp_err;

    logic [31:0] rf [32];

    svr_read_sched #(.NREQ(2), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_vl(req_vl),
        .svr_ra(svr_ra), .svr_rd(svr_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Register file model: four consecutive words, wrapping at 32.
    always_comb begin
        svr_rd = '0;
        for (int j = 0; j < 4; j++)
            svr_rd[32*j +: 32] = rf[5'(svr_ra + 5'(j))];
    end

    int nchk = 0;
    int nerr = 0;

    // Model state: a pending transaction and cycles elapsed since its grant.
    bit          m_busy = 0;
    int          m_t = 0;
    int          m_lat = 0;
    bit          m_prio = 0;
    bit          m_id = 0;
    bit          m_err = 0;
    logic [4:0]  m_base = '0;
    logic [511:0] m_exp = '0;
    int          grants[$];

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rst_pulse();
        #2;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 512'(req_ready), 512'(0));
        chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
        chk("rst_rsp_id",    512'(rsp_id),    512'(0));
        chk("rst_rsp_data",  rsp_data,        512'(0));
        chk("rst_rsp_err",   512'(rsp_err),   512'(0));
        chk("rst_svr_ra",    512'(svr_ra),    512'(0));
        m_busy = 0;
        m_prio = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, check just after, advance model at posedge.
    task automatic cycle(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [1:0] l0, input logic [1:0] l1, input logic rr);
        logic [1:0]  exp_rdy;
        logic        win;
        logic [4:0]  exp_ra;
        logic [1:0]  vl;
        int          n;
        @(negedge clk);
        req_valid = v;
        req_addr[0] = a0; req_addr[1] = a1;
        req_vl[0] = l0;   req_vl[1] = l1;
        rsp_ready = rr;
        #1;
        win = v[m_prio] ? m_prio : ~m_prio;
        exp_rdy = (!m_busy && v != 2'b00) ? (2'b01 << win) : 2'b00;
        chk("req_ready", 512'(req_ready), 512'(exp_rdy));
        chk("onehot", 512'(req_ready == 2'b11), 512'(0));
        chk("rsp_valid", 512'(rsp_valid), 512'(m_busy && m_t >= m_lat));
        if (m_busy && m_t >= m_lat) begin
            chk("rsp_id",   512'(rsp_id),  512'(m_id));
            chk("rsp_data", rsp_data,      m_exp);
            chk("rsp_err",  512'(rsp_err), 512'(m_err));
        end
        exp_ra = (m_busy && !m_err && m_t >= 1 && m_t < m_lat) ? 5'(m_base + 5'(4*(m_t-1))) : 5'd0;
        chk("svr_ra", 512'(svr_ra), 512'(exp_ra));
        if (exp_rdy != 2'b00) grants.push_back(int'(req_ready[1]));
        @(posedge clk);
        if (!m_busy) begin
            if (exp_rdy != 2'b00) begin
                vl     = win ? l1 : l0;
                m_base = win ? a1 : a0;
                m_id   = win;
                m_prio = ~win;
                m_err  = (vl == 2'b11);
                m_lat  = (vl == 2'b11) ? 1 : (vl == 2'b10) ? 5 : 2;
                n      = (vl == 2'b00) ? 1 : (vl == 2'b01) ? 4 : (vl == 2'b10) ? 16 : 0;
                m_exp  = '0;
                for (int k = 0; k < n; k++)
                    m_exp[32*k +: 32] = rf[5'(m_base + 5'(k))];
                m_busy = 1;
                m_t    = 1;
            end
        end else if (m_t >= m_lat) begin
            if (rr) m_busy = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'h100 + k;
        rst_pulse();

        // Single word, requester 0.
        cycle(2'b01, 5'd3, 5'd0, 2'b00, 2'b00, 1'b1);
        idle(4);
        // Sixteen words, requester 1.
        cycle(2'b10, 5'd0, 5'd8, 2'b00, 2'b10, 1'b1);
        idle(7);
        // Wrap-around.
        cycle(2'b01, 5'd30, 5'd0, 2'b10, 2'b00, 1'b1);
        idle(7);

        // Contention: grants must alternate.
        grants.delete();
        for (int i = 0; i < 13; i++) cycle(2'b11, 5'd4, 5'd20, 2'b01, 2'b01, 1'b1);
        idle(3);
        chk("ngrants", 512'(grants.size() >= 4), 512'(1));
        for (int i = 1; i < grants.size(); i++)
            chk("alternate", 512'(grants[i]), 512'(grants[i-1] ^ 1));

        // Illegal length with backpressure, other requester pushing meanwhile.
        cycle(2'b01, 5'd7, 5'd9, 2'b11, 2'b01, 1'b0);
        for (int i = 0; i < 10; i++) cycle(2'b11, 5'd7, 5'd9, 2'b01, 2'b01, 1'b0);
        cycle(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1);
        idle(3);

        // Reset during beat 2 of a sixteen-word read.
        cycle(2'b01, 5'd5, 5'd0, 2'b10, 2'b00, 1'b1);
        idle(2);
        rst_pulse();
        cycle(2'b10, 5'd0, 5'd17, 2'b00, 2'b10, 1'b1);
        idle(7);

        // Pointer must return to requester 0 after reset.
        cycle(2'b01, 5'd1, 5'd0, 2'b01, 2'b00, 1'b1);
        idle(1);
        rst_pulse();
        cycle(2'b11, 5'd12, 5'd13, 2'b01, 2'b01, 1'b1);
        idle(4);

        // Randomized traffic over a random register file.
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) rst_pulse();
            cycle(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
